// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, size codes, clear FSM states and alignment helper for the MEM stage
package mem_pkg;

  localparam int DEFAULT_MEM_BUS_SIZE  = 32;
  localparam int DEFAULT_MEM_ADDR_BITS = 5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

  typedef enum logic {
    MEM_ST_IDLE  = 1'b0,
    MEM_ST_CLEAR = 1'b1
  } mem_state_e;

  // Size code 2'b10 falls into the word case on purpose.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_SIZE_BYTE: is_aligned = 1'b1;
      MEM_SIZE_HALF: is_aligned = ~lane[0];
      default:       is_aligned = (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_data_memory.sv
// rtl/mem_data_memory.sv - word-organised data memory, byte-enable sync write, comb read and debug ports
module mem_data_memory #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]     dbg_data
);

  logic [WIDTH-1:0] words [1<<ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < WIDTH/8; b++) begin
      if (wr_be[b]) words[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign rd_data  = words[rd_addr];
  assign dbg_data = words[dbg_addr];

endmodule

// File: rtl/mem.sv
// rtl/mem.sv - MEM pipeline stage: lane-aligned loads/stores, zero-fill sequencer and MEM/WB register
module mem
  import mem_pkg::*;
#(
  parameter int BUS_SIZE      = DEFAULT_MEM_BUS_SIZE,
  parameter int MEM_ADDR_BITS = DEFAULT_MEM_ADDR_BITS
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_halt,
  input  logic                     i_mem_clear,
  input  logic                     i_mem_rd,
  input  logic                     i_mem_wr,
  input  logic [1:0]               i_mem_size,
  input  logic                     i_mem_unsigned,
  input  logic                     i_reg_write,
  input  logic                     i_mem_to_reg,
  input  logic [4:0]               i_wb_addr,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  input  logic [BUS_SIZE-1:0]      i_sc_bus_b,
  input  logic [MEM_ADDR_BITS-1:0] i_debug_addr,
  output logic [BUS_SIZE-1:0]      o_debug_data,
  output logic                     o_busy,
  output logic                     o_reg_write,
  output logic                     o_mem_to_reg,
  output logic [4:0]               o_wb_addr,
  output logic [BUS_SIZE-1:0]      o_alu_result,
  output logic [BUS_SIZE-1:0]      o_mem_data,
  output logic                     o_misaligned
);

  localparam int LANES = BUS_SIZE / 8;

  mem_state_e               state, state_next;
  logic [MEM_ADDR_BITS-1:0] clr_idx, clr_idx_next;
  logic                     busy, clr_we;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= MEM_ST_IDLE;
      clr_idx <= '0;
    end else if (!i_halt) begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    busy         = 1'b0;
    clr_we       = 1'b0;
    case (state)
      MEM_ST_IDLE: begin
        if (i_mem_clear) begin
          state_next   = MEM_ST_CLEAR;
          clr_idx_next = '0;
        end
      end
      MEM_ST_CLEAR: begin
        busy         = 1'b1;
        clr_we       = ~i_halt & ~i_reset;
        clr_idx_next = clr_idx + 1'b1;
        if (&clr_idx) state_next = MEM_ST_IDLE;
      end
      default: state_next = MEM_ST_IDLE;
    endcase
  end

  assign o_busy = busy;

  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [1:0]               lane;
  logic                     aligned, store_en, load_en;

  assign word_idx = i_alu_result[MEM_ADDR_BITS+1:2];
  assign lane     = i_alu_result[1:0];
  assign aligned  = is_aligned(i_mem_size, lane);
  assign store_en = i_mem_wr & aligned & ~i_halt & ~busy & ~i_reset;
  // A simultaneous rd+wr is a store; it must not also produce load data.
  assign load_en  = i_mem_rd & ~i_mem_wr & aligned & ~busy;

  logic [LANES-1:0]    st_be;
  logic [BUS_SIZE-1:0] st_data;

  always_comb begin
    st_be   = '0;
    st_data = i_sc_bus_b;
    case (i_mem_size)
      MEM_SIZE_BYTE: begin
        st_be   = LANES'(1) << lane;
        st_data = {LANES{i_sc_bus_b[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_sc_bus_b[15:0]}};
      end
      default: st_be = '1;
    endcase
  end

  logic [LANES-1:0]         wr_be;
  logic [MEM_ADDR_BITS-1:0] wr_addr;
  logic [BUS_SIZE-1:0]      wr_data, rd_word;

  assign wr_be   = clr_we ? '1 : (store_en ? st_be : '0);
  assign wr_addr = clr_we ? clr_idx : word_idx;
  assign wr_data = clr_we ? '0 : st_data;

  mem_data_memory #(
    .WIDTH     (BUS_SIZE),
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_data_memory (
    .clk      (i_clk),
    .wr_be    (wr_be),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (word_idx),
    .rd_data  (rd_word),
    .dbg_addr (i_debug_addr),
    .dbg_data (o_debug_data)
  );

  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [BUS_SIZE-1:0] load_val;

  assign ld_byte = rd_word[8*lane +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    case (i_mem_size)
      MEM_SIZE_BYTE: load_val = {{(BUS_SIZE-8){~i_mem_unsigned & ld_byte[7]}}, ld_byte};
      MEM_SIZE_HALF: load_val = {{(BUS_SIZE-16){~i_mem_unsigned & ld_half[15]}}, ld_half};
      default:       load_val = rd_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_wb_addr    <= '0;
      o_alu_result <= '0;
      o_mem_data   <= '0;
      o_misaligned <= 1'b0;
    end else if (!i_halt) begin
      o_reg_write  <= i_reg_write & ~busy;
      o_mem_to_reg <= i_mem_to_reg;
      o_wb_addr    <= i_wb_addr;
      o_alu_result <= i_alu_result;
      o_mem_data   <= load_en ? load_val : '0;
      o_misaligned <= (i_mem_rd | i_mem_wr) & ~aligned & ~busy;
    end
  end

endmodule

// File: tb/tb_mem.sv
// tb/tb_mem.sv - self-checking bench for the MEM stage: vector table with scoreboard plus clear/halt/reset sequences
module tb_mem;

  logic        i_clk = 1'b0;
  logic        i_reset, i_halt, i_mem_clear, i_mem_rd, i_mem_wr, i_mem_unsigned;
  logic        i_reg_write, i_mem_to_reg;
  logic [1:0]  i_mem_size;
  logic [4:0]  i_wb_addr, i_debug_addr;
  logic [31:0] i_alu_result, i_sc_bus_b;
  logic [31:0] o_debug_data, o_alu_result, o_mem_data;
  logic        o_busy, o_reg_write, o_mem_to_reg, o_misaligned;
  logic [4:0]  o_wb_addr;

  mem dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_mem_clear(i_mem_clear),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_mem_size(i_mem_size),
    .i_mem_unsigned(i_mem_unsigned), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_wb_addr(i_wb_addr), .i_alu_result(i_alu_result), .i_sc_bus_b(i_sc_bus_b),
    .i_debug_addr(i_debug_addr), .o_debug_data(o_debug_data), .o_busy(o_busy),
    .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg), .o_wb_addr(o_wb_addr),
    .o_alu_result(o_alu_result), .o_mem_data(o_mem_data), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr, rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, exp_data;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] data, alu;
    logic        mis, rw, m2r;
    logic [4:0]  wba;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_halt = 0; i_mem_clear = 0; i_mem_rd = 0; i_mem_wr = 0; i_mem_size = 2'b11;
    i_mem_unsigned = 0; i_reg_write = 0; i_mem_to_reg = 0; i_wb_addr = 0;
    i_alu_result = 0; i_sc_bus_b = 0;
  endtask

  task automatic add(input logic wr, input logic rd, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_mis);
    vec_t v;
    v.wr = wr; v.rd = rd; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_data = exp_data; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    idle();
    i_mem_wr = 1; i_alu_result = addr; i_sc_bus_b = data;
    step();
    idle();
  endtask

  task automatic dbg(input string name, input logic [4:0] idx, input logic [31:0] exp);
    i_debug_addr = idx;
    #1;
    chk(name, o_debug_data, exp);
  endtask

  initial begin
    int   cnt;
    exp_t e;
    idle();
    i_debug_addr = 0;
    i_reset = 1;
    step(); step();
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_mem_data", o_mem_data, 32'd0);
    chk("reset_reg_write", {31'd0, o_reg_write}, 32'd0);
    chk("reset_alu", o_alu_result, 32'd0);
    i_reset = 0;

    //   wr rd size   uns addr         wdata         exp_data      mis
    add(1, 0, 2'b11, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0);
    add(0, 1, 2'b11, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    add(0, 1, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0);
    add(0, 1, 2'b00, 1, 32'h13, 32'h0,        32'h000000DE, 0);
    add(0, 1, 2'b01, 0, 32'h10, 32'h0,        32'hFFFFBEEF, 0);
    add(0, 1, 2'b01, 1, 32'h10, 32'h0,        32'h0000BEEF, 0);
    add(1, 0, 2'b00, 0, 32'h11, 32'h12345678, 32'h00000000, 0);
    add(0, 1, 2'b11, 0, 32'h10, 32'h0,        32'hDEAD78EF, 0);
    add(1, 0, 2'b01, 0, 32'h11, 32'hFFFFFFFF, 32'h00000000, 1);
    add(0, 1, 2'b11, 0, 32'h10, 32'h0,        32'hDEAD78EF, 0);
    add(0, 1, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFDEAD, 0);
    add(1, 0, 2'b11, 0, 32'h80, 32'hA5A5A5A5, 32'h00000000, 0);
    add(0, 1, 2'b11, 0, 32'h00, 32'h0,        32'hA5A5A5A5, 0);
    add(0, 1, 2'b11, 0, 32'h02, 32'h0,        32'h00000000, 1);
    add(1, 1, 2'b11, 0, 32'h04, 32'h11223344, 32'h00000000, 0);
    add(0, 1, 2'b11, 0, 32'h04, 32'h0,        32'h11223344, 0);
    add(0, 1, 2'b00, 0, 32'h05, 32'h0,        32'h00000033, 0);
    add(1, 0, 2'b00, 0, 32'h06, 32'h00000080, 32'h00000000, 0);
    add(0, 1, 2'b00, 0, 32'h06, 32'h0,        32'hFFFFFF80, 0);
    add(0, 1, 2'b00, 1, 32'h06, 32'h0,        32'h00000080, 0);
    add(0, 1, 2'b10, 0, 32'h04, 32'h0,        32'h11803344, 0);

    foreach (vecs[i]) begin
      i_mem_wr = vecs[i].wr; i_mem_rd = vecs[i].rd; i_mem_size = vecs[i].size;
      i_mem_unsigned = vecs[i].uns; i_alu_result = vecs[i].addr; i_sc_bus_b = vecs[i].wdata;
      i_reg_write = vecs[i].rd; i_mem_to_reg = vecs[i].rd; i_wb_addr = 5'(i + 1);
      e.data = vecs[i].exp_data; e.mis = vecs[i].exp_mis; e.alu = vecs[i].addr;
      e.rw = vecs[i].rd; e.m2r = vecs[i].rd; e.wba = 5'(i + 1);
      sb.push_back(e);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_data", i), o_mem_data, e.data);
      chk($sformatf("v%0d_mis", i), {31'd0, o_misaligned}, {31'd0, e.mis});
      chk($sformatf("v%0d_alu", i), o_alu_result, e.alu);
      chk($sformatf("v%0d_rw", i), {31'd0, o_reg_write}, {31'd0, e.rw});
      chk($sformatf("v%0d_m2r", i), {31'd0, o_mem_to_reg}, {31'd0, e.m2r});
      chk($sformatf("v%0d_wba", i), {27'd0, o_wb_addr}, {27'd0, e.wba});
    end
    idle();
    dbg("dbg_word4", 5'd4, 32'hDEAD78EF);

    // Zero-fill: busy for exactly 32 cycles, a store issued while busy is dropped.
    i_mem_clear = 1;
    step();
    i_mem_clear = 0;
    chk("clear_busy_start", {31'd0, o_busy}, 32'd1);
    i_mem_wr = 1; i_reg_write = 1; i_alu_result = 32'h10; i_sc_bus_b = 32'hFFFFFFFF;
    cnt = 0;
    while (o_busy && cnt < 100) begin
      cnt++;
      step();
      if (cnt == 1) begin
        chk("busy_reg_write", {31'd0, o_reg_write}, 32'd0);
        idle();
      end
    end
    chk("clear_cycles", cnt, 32);
    for (int w = 0; w < 32; w++) dbg($sformatf("clear_w%0d", w), 5'(w), 32'd0);

    // Halt over a store: no write and MEM/WB holds the preceding load.
    store(32'h20, 32'h0BADF00D);
    i_mem_rd = 1; i_reg_write = 1; i_mem_to_reg = 1; i_wb_addr = 5'd3; i_alu_result = 32'h20;
    step();
    chk("pre_halt_data", o_mem_data, 32'h0BADF00D);
    idle();
    i_halt = 1; i_mem_wr = 1; i_alu_result = 32'h20; i_sc_bus_b = 32'h12345678; i_wb_addr = 5'd7;
    for (int h = 0; h < 3; h++) begin
      step();
      chk($sformatf("halt%0d_data", h), o_mem_data, 32'h0BADF00D);
      chk($sformatf("halt%0d_wba", h), {27'd0, o_wb_addr}, 32'd3);
      chk($sformatf("halt%0d_rw", h), {31'd0, o_reg_write}, 32'd1);
      dbg($sformatf("halt%0d_mem", h), 5'd8, 32'h0BADF00D);
    end
    idle();
    step();
    chk("post_halt_data", o_mem_data, 32'd0);

    // Reset in the middle of a clear aborts it with the tail of memory untouched.
    store(32'h00, 32'h00000077);
    store(32'h7C, 32'h5555AAAA);
    i_mem_clear = 1;
    step();
    i_mem_clear = 0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_clear_busy", {31'd0, o_busy}, 32'd1);
    i_reset = 1; i_mem_rd = 1; i_reg_write = 1; i_alu_result = 32'h7C;
    step();
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_data", o_mem_data, 32'd0);
    chk("abort_alu", o_alu_result, 32'd0);
    chk("abort_rw", {31'd0, o_reg_write}, 32'd0);
    i_reset = 0;
    idle();
    step();
    chk("abort_busy_after", {31'd0, o_busy}, 32'd0);
    dbg("abort_w0", 5'd0, 32'd0);
    dbg("abort_w31", 5'd31, 32'h5555AAAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
